// File: rtl/div_unit_if.sv
// Execute-to-divider bundle: operands/control toward the divider, result/ready back.
interface div_unit_if #(parameter int DATA_W = 32);
  logic                signed_div_i;
  logic [DATA_W-1:0]   opdata1_i;
  logic [DATA_W-1:0]   opdata2_i;
  logic                start_i;
  logic                annul_i;
  logic [2*DATA_W-1:0] result_o;
  logic                ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider; result = {remainder, quotient}.
module div_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic     clk,
  input  logic     rst,
  div_unit_if.slave bus
);
  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W);

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_dvd, r_dvs, r_rem, r_quo;
  logic                r_neg_q, r_neg_r;
  logic [2*DATA_W-1:0] r_result, w_result_nxt;
  logic                r_ready, w_ready_nxt;

  logic                w_a_neg, w_b_neg, w_go, w_ge;
  logic [DATA_W-1:0]   w_a_mag, w_b_mag, w_quo_fix, w_rem_fix;
  logic [DATA_W:0]     w_part, w_diff;

  // Magnitude of the most negative value wraps to itself, which reads correctly as unsigned.
  assign w_a_neg = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
  assign w_b_neg = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
  assign w_a_mag = w_a_neg ? -bus.opdata1_i : bus.opdata1_i;
  assign w_b_mag = w_b_neg ? -bus.opdata2_i : bus.opdata2_i;
  assign w_go    = bus.start_i & ~bus.annul_i & (bus.opdata2_i != '0);

  assign w_part  = {r_rem, r_dvd[DATA_W-1]};
  assign w_ge    = (w_part >= {1'b0, r_dvs});
  assign w_diff  = w_part - {1'b0, r_dvs};

  assign w_quo_fix = r_neg_q ? -r_quo : r_quo;
  assign w_rem_fix = r_neg_r ? -r_rem : r_rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= FREE;
      r_result <= '0;
      r_ready  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_result <= w_result_nxt;
      r_ready  <= w_ready_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_result_nxt = r_result;
    w_ready_nxt  = r_ready;
    case (r_state)
      FREE: begin
        w_result_nxt = '0;
        w_ready_nxt  = 1'b0;
        if (bus.start_i && !bus.annul_i)
          w_state_nxt = (bus.opdata2_i == '0) ? BYZERO : ON;
      end
      BYZERO: begin
        w_result_nxt = '0;
        if (bus.annul_i) begin
          w_state_nxt = FREE;
          w_ready_nxt = 1'b0;
        end else begin
          w_state_nxt = END;
          w_ready_nxt = 1'b1;
        end
      end
      ON: begin
        if (bus.annul_i) begin
          w_state_nxt  = FREE;
          w_result_nxt = '0;
          w_ready_nxt  = 1'b0;
        end else if (r_cnt == LAST) begin
          w_state_nxt  = END;
          w_result_nxt = {w_rem_fix, w_quo_fix};
          w_ready_nxt  = 1'b1;
        end
      end
      END: begin
        if (!bus.start_i) begin
          w_state_nxt  = FREE;
          w_result_nxt = '0;
          w_ready_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt  = FREE;
        w_result_nxt = '0;
        w_ready_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else begin
      case (r_state)
        FREE: begin
          if (w_go) begin
            r_cnt   <= '0;
            r_dvd   <= w_a_mag;
            r_dvs   <= w_b_mag;
            r_rem   <= '0;
            r_quo   <= '0;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
          end
        end
        ON: begin
          if (bus.annul_i) begin
            r_cnt <= '0;
          end else if (r_cnt != LAST) begin
            r_rem <= w_ge ? w_diff[DATA_W-1:0] : w_part[DATA_W-1:0];
            r_quo <= {r_quo[DATA_W-2:0], w_ge};
            r_dvd <= {r_dvd[DATA_W-2:0], 1'b0};
            r_cnt <= r_cnt + 1'b1;
          end
        end
        BYZERO: r_cnt <= '0;
        default: ;
      endcase
    end
  end

  assign bus.result_o = r_result;
  assign bus.ready_o  = r_ready;
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit with an expected-result queue.
module tb_div_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  logic [63:0] sb[$];

  div_unit_if #(.DATA_W(32)) bus();
  div_unit #(.DATA_W(32), .CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait up to 60 edges after the start edge for ready; returns edge index.
  task automatic wait_ready(output int n);
    n = 0;
    while (n < 60) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (bus.ready_o) break;
    end
  endtask

  task automatic run(input string tag, input bit sg, input logic [31:0] a, input logic [31:0] b,
                     input logic [63:0] exp, input int lat);
    int n;
    logic [63:0] e;
    @(negedge clk);
    bus.signed_div_i = sg; bus.opdata1_i = a; bus.opdata2_i = b; bus.start_i = 1'b1;
    sb.push_back(exp);
    @(posedge clk); #1;
    // Scramble operands after the start edge; they must not matter.
    bus.opdata1_i = $urandom; bus.opdata2_i = $urandom; bus.signed_div_i = ~sg;
    wait_ready(n);
    chk({tag, "_lat"}, 64'(n), 64'(lat));
    e = sb.pop_front();
    chk({tag, "_res"}, bus.result_o, e);
    @(posedge clk); @(negedge clk);
    chk({tag, "_hold"}, {bus.ready_o, bus.result_o[62:0]}, {1'b1, e[62:0]});
    bus.start_i = 1'b0;
    @(posedge clk); @(negedge clk);
    chk({tag, "_clr"}, {bus.ready_o, bus.result_o[62:0]}, 64'd0);
  endtask

  task automatic quiet(input string tag, input int cycles);
    int hits = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.ready_o) hits++;
    end
    chk(tag, 64'(hits), 64'd0);
  endtask

  initial begin
    int n;
    bus.signed_div_i = 1'b0; bus.opdata1_i = '0; bus.opdata2_i = '0;
    bus.start_i = 1'b0; bus.annul_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset", {bus.ready_o, bus.result_o[62:0]}, 64'd0);
    rst = 1'b0;

    run("u7_2",    1'b0, 32'd7,        32'd2,        64'h00000001_00000003, 33);
    run("s-7_2",   1'b1, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, 33);
    run("s7_-2",   1'b1, 32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33);
    run("uFFFF",   1'b0, 32'hFFFFFFFF, 32'h10,       64'h0000000F_0FFFFFFF, 33);
    run("smin_-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33);
    run("u0_5",    1'b0, 32'd0,        32'd5,        64'd0,                 33);
    run("byzero",  1'b0, 32'd123,      32'd0,        64'd0,                 1);
    run("s-9_-4",  1'b1, 32'hFFFFFFF7, 32'hFFFFFFFC, 64'hFFFFFFFF_00000002, 33);

    // Annul at iteration 10, then a fresh division two cycles later.
    @(negedge clk);
    bus.signed_div_i = 1'b0; bus.opdata1_i = 32'd1000; bus.opdata2_i = 32'd3; bus.start_i = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.annul_i = 1'b1; bus.start_i = 1'b0;
    @(posedge clk); @(negedge clk);
    bus.annul_i = 1'b0;
    chk("annul_free", {bus.ready_o, bus.result_o[62:0]}, 64'd0);
    @(negedge clk);
    run("u100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33);
    quiet("annul_quiet", 5);

    // Start with annul in FREE is ignored.
    @(negedge clk);
    bus.opdata1_i = 32'd50; bus.opdata2_i = 32'd5; bus.start_i = 1'b1; bus.annul_i = 1'b1;
    quiet("start_annul", 40);
    bus.start_i = 1'b0; bus.annul_i = 1'b0;

    // Asynchronous reset while the result is held.
    @(negedge clk);
    bus.signed_div_i = 1'b0; bus.opdata1_i = 32'd9; bus.opdata2_i = 32'd4; bus.start_i = 1'b1;
    @(posedge clk);
    wait_ready(n);
    chk("pre_rst", {bus.ready_o, bus.result_o[62:0]}, {1'b1, 63'h00000001_00000002});
    #2 rst = 1'b1;
    #1 chk("async_rst", {bus.ready_o, bus.result_o[62:0]}, 64'd0);
    bus.start_i = 1'b0;
    @(negedge clk); rst = 1'b0;

    // Reset mid-iteration abandons the operation.
    @(negedge clk);
    bus.opdata1_i = 32'd77; bus.opdata2_i = 32'd7; bus.start_i = 1'b1;
    repeat (15) @(posedge clk);
    #2 rst = 1'b1; bus.start_i = 1'b0;
    @(negedge clk); rst = 1'b0;
    quiet("rst_mid_on", 40);

    run("u_after", 1'b0, 32'd77, 32'd7, 64'h00000000_0000000B, 33);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider for the execute stage, directly downstream of instruction decode.
- Decode classifies DIV/DIVU. Execute then forwards decode's operand values and signedness to this block and holds start_i.
- Execute stalls the pipeline until ready_o is high, then writes result_o to HI/LO: HI = remainder, LO = quotient.

Parameters:
- DATA_W, 32, operand width; result_o is 2*DATA_W wide.
- CNT_W, 6, iteration counter width; must hold DATA_W.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- signed_div_i  in  1  1 = DIV (two's complement), 0 = DIVU.
- opdata1_i  in  32  dividend.
- opdata2_i  in  32  divisor.
- start_i  in  1  request. Held high by execute until it has consumed ready_o.
- annul_i  in  1  cancel an in-flight division (branch flush / exception).
- result_o  out  64  {remainder[31:0], quotient[31:0]}. Registered.
- ready_o  out  1  result valid. Registered.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-high. Clock port is clk, reset port is rst.
- Reset, asynchronous:
  - state=FREE, counter=0, internal remainder/quotient registers cleared.
  - result_o=0, ready_o=0.
  - Reset mid-division abandons the operation with no output.
- States: FREE, BYZERO, ON, END.
- FREE:
  - ready_o=0, result_o=0.
  - At an edge where start_i=1 and annul_i=0:
    - opdata2_i==0 -> BYZERO.
    - otherwise -> ON. Latch operands and signedness, clear counter.
  - start_i with annul_i=1 is ignored.
- Operand conditioning at latch:
  - Signed mode: operands with MSB set are replaced by their two's-complement magnitude.
  - The magnitude of 0x80000000 is treated as unsigned 0x80000000.
  - Unsigned mode uses raw values.
- Operands are sampled only at the start edge. Later changes on opdata*_i are ignored.
- ON:
  - One iteration per edge, dividend bits MSB-first.
  - Each iteration: partial remainder = {partial remainder, next dividend bit}. If it is >= divisor magnitude, subtract the divisor and shift quotient bit 1; else shift 0.
  - After 32 iterations (counter==32), at the next edge -> END. That edge registers the sign-corrected result and sets ready_o=1.
  - Sign correction (signed mode only): quotient negated when the operand sign bits differ; remainder negated when the dividend was negative.
  - -2^31 / -1 yields quotient 0x80000000, remainder 0 (wraps, no trap).
- Latency:
  - Start sampled at edge E0; iterations at E1..E32; result registered at E33.
  - ready_o is first high in the cycle after E33.
- BYZERO: at the next edge -> END with result_o=0, ready_o=1. ready_o is first high after E1.
- annul_i=1 while in ON or BYZERO: at that edge -> FREE, result_o=0, ready_o=0, counter cleared.
- END:
  - result_o and ready_o held stable while start_i=1. annul_i is ignored in END.
  - At an edge with start_i=0 -> FREE, ready_o=0, result_o=0.
  - Back-to-back divisions therefore require start_i to drop for at least one edge.
- No combinational path from any input to any output.

Test Plan:
- Unsigned 7/2: signed_div_i=0, opdata1=7, opdata2=2, start held -> ready_o high exactly 33 cycles after start edge. result_o=0x00000001_00000003 held while start=1; both clear one cycle after start drops.
- Signed -7/2: opdata1=0xFFFFFFF9, opdata2=2, signed_div_i=1 -> result_o=0xFFFFFFFF_FFFFFFFD. Also check 7/-2 -> 0x00000001_FFFFFFFD.
- Extremes:
  - Unsigned 0xFFFFFFFF/0x10 -> 0x0000000F_0FFFFFFF.
  - Signed 0x80000000/0xFFFFFFFF -> 0x00000000_80000000.
- Divide by zero: opdata2=0 -> ready_o high after E1 with result_o=0. Dividend 0 with nonzero divisor -> full 33-cycle latency, result 0.
- Annul: annul_i pulsed at iteration 10 -> FREE next edge, ready_o never rises. A new start two cycles later (100/7 unsigned) -> 0x00000002_0000000E after 33 cycles.
- Robustness:
  - rst asserted mid-ON between clock edges -> outputs 0 immediately (asynchronous).
  - Operands changed after E0 -> result unaffected.
  - start_i with annul_i=1 in FREE -> no activity.
